// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, decimal limits, FSM states
// and per-nibble helpers used by the serial BCD adder.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic is_bcd(
        input logic [BCD_DIGIT_W-1:0] d
    );
        return d <= BCD_MAX;
    endfunction

    function automatic logic [BCD_DIGIT_W-1:0] nines_comp(
        input logic [BCD_DIGIT_W-1:0] d
    );
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit decimal adder: a + b + ci with +6 correction
// when the binary digit sum exceeds nine.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   ci,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   co
);

    logic [BCD_DIGIT_W:0] s;

    // binary sum, then decimal correction on overflow past 9
    always_comb begin
        s = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, ci};
        if (s > {1'b0, BCD_MAX}) begin
            digit = s[BCD_DIGIT_W-1:0] + BCD_CORR;
            co    = 1'b1;
        end else begin
            digit = s[BCD_DIGIT_W-1:0];
            co    = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, DPC digits per cycle.
// Define BCD_SUB_EN to add the op port (1 = a - b via nines complement).
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DPC      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*N_DIGITS-1:0] a,
    input  logic [4*N_DIGITS-1:0] b,
    input  logic                  cin,
`ifdef BCD_SUB_EN
    input  logic                  op,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*N_DIGITS-1:0] sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W  = BCD_DIGIT_W * N_DIGITS;
    localparam int GW = BCD_DIGIT_W * DPC;
    localparam int NG = N_DIGITS / DPC;
    localparam int CW = (NG > 1) ? $clog2(NG) : 1;

    generate
        if (DPC < 1 || N_DIGITS < 1 || (N_DIGITS % DPC) != 0) begin : g_bad_cfg
            $error("bcd_serial_adder: DPC must divide N_DIGITS");
        end
    endgenerate

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    b_in;
    logic            c_in;
    logic            bad;
    logic [DPC:0]    ch;
    logic [GW-1:0]   grp_sum;
    logic [W+GW-1:0] sum_sh;

    // any non-decimal nibble in either operand poisons the op
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!is_bcd(a[BCD_DIGIT_W*i +: BCD_DIGIT_W]) ||
                !is_bcd(b[BCD_DIGIT_W*i +: BCD_DIGIT_W])) begin
                bad = 1'b1;
            end
        end
    end

`ifdef BCD_SUB_EN
    // subtract becomes a + nines(b) + 1
    always_comb begin
        b_in = b;
        c_in = cin;
        if (op) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                b_in[BCD_DIGIT_W*i +: BCD_DIGIT_W] =
                    nines_comp(b[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
            end
            c_in = 1'b1;
        end
    end
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign ch[0] = carry;

    for (genvar g = 0; g < DPC; g++) begin : g_dig
        bcd_digit_adder u_dig (
            .a     (a_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .b     (b_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .ci    (ch[g]),
            .digit (grp_sum[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .co    (ch[g+1])
        );
    end

    // new digits enter at the top; after NG groups digit 0 sits at [3:0]
    assign sum_sh = {grp_sum, sum};

    // control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            err       <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b_in;
                        carry    <= c_in;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        sum      <= '0;
                        cout     <= 1'b0;
                        err      <= bad;
                        state    <= bad ? DONE : RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> GW;
                    b_q   <= b_q >> GW;
                    sum   <= sum_sh[W+GW-1:GW];
                    carry <= ch[DPC];
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(NG - 1)) begin
                        cout      <= ch[DPC];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomised self-checking bench for bcd_serial_adder against
// a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

    localparam int N   = 4;
    localparam int DPC = 1;
    localparam int W   = 4 * N;
    localparam longint P = 10 ** N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef BCD_SUB_EN
    logic         op;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_err;
    int           exp_lat;
    bit           have_exp = 0;
    bit           armed = 0;
    bit           seen = 0;
    int           pe = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.N_DIGITS(N), .DPC(DPC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef BCD_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic longint dec(input logic [W-1:0] x);
        longint v = 0;
        for (int i = N - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] enc(input longint v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit all_bcd(input logic [W-1:0] x);
        for (int i = 0; i < N; i++) if (x[4*i +: 4] > 4'd9) return 0;
        return 1;
    endfunction

    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic sub,
                         output logic [W-1:0] s, output logic co,
                         output logic e, output int lat);
        longint t;
        if (!all_bcd(x) || !all_bcd(y)) begin
            s = '0; co = 1'b0; e = 1'b1; lat = 1;
        end else begin
            if (sub) t = dec(x) + (P - 1 - dec(y)) + 1;
            else     t = dec(x) + dec(y) + longint'(ci);
            co = (t >= P);
            s = enc(t % P);
            e = 1'b0;
            lat = N / DPC;
        end
    endtask

    task automatic pin(input string name, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic ci,
                       input logic sub, input logic [W-1:0] ws,
                       input logic wc, input logic we, input int wl);
        logic [W-1:0] s;
        logic co, e;
        int lat;
        model(x, y, ci, sub, s, co, e, lat);
        chk({name, "_sum"}, s, ws);
        chk({name, "_cout"}, co, wc);
        chk({name, "_err"}, e, we);
        chk({name, "_lat"}, lat, wl);
    endtask

    always @(posedge clk) if (armed) pe++;

    // every cycle with a result on the bus must match the model
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!have_exp) begin
                chk("spurious_valid", out_valid, 0);
            end else begin
                chk("sum", sum, exp_sum);
                chk("cout", cout, exp_cout);
                chk("err", err, exp_err);
                chk("done_in_ready", in_ready, 0);
                if (!seen) begin
                    chk("latency", pe, exp_lat);
                    seen = 1;
                end
            end
        end else if (rst_n && armed) begin
            chk("busy_in_ready", in_ready, 0);
        end
    end

    task automatic scramble_inputs();
        in_valid = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
`ifdef BCD_SUB_EN
        op = 1'($urandom);
`endif
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sub, input int hold);
        int n;
        @(negedge clk);
        a = x; b = y; cin = ci;
`ifdef BCD_SUB_EN
        op = sub;
`endif
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        model(x, y, ci, sub, exp_sum, exp_cout, exp_err, exp_lat);
        have_exp = 1;
        seen = 0;
        @(posedge clk);
        #1;
        pe = 0;
        armed = 1;
        scramble_inputs();
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", out_valid, 1);
        repeat (hold) @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        have_exp = 0;
        armed = 0;
        @(negedge clk);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] x, y;
        logic s;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
`ifdef BCD_SUB_EN
        op = 1'b0;
`endif
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        pin("p_0999", 16'h0999, 16'h0001, 0, 0, 16'h1000, 0, 0, N / DPC);
        pin("p_wrap", 16'h9999, 16'h0001, 0, 0, 16'h0000, 1, 0, N / DPC);
        pin("p_full", 16'h9999, 16'h9999, 1, 0, 16'h9999, 1, 0, N / DPC);
        pin("p_bad", 16'h12A4, 16'h0001, 0, 0, 16'h0000, 0, 1, 1);

        run_op(16'h0999, 16'h0001, 0, 0, 0);
        run_op(16'h9999, 16'h0001, 0, 0, 1);
        run_op(16'h9999, 16'h9999, 1, 0, 0);
        run_op(16'h12A4, 16'h0001, 0, 0, 2);
        run_op(16'h4321, 16'h1234, 1, 0, 10);

        // reset two cycles into RUN drops the result at once
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_cout", cout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pin("p_0005", 16'h0005, 16'h0005, 0, 0, 16'h0010, 0, 0, N / DPC);
        run_op(16'h0005, 16'h0005, 0, 0, 0);

`ifdef BCD_SUB_EN
        pin("p_sub_pos", 16'h0100, 16'h0001, 0, 1, 16'h0099, 1, 0, N / DPC);
        pin("p_sub_neg", 16'h0001, 16'h0002, 0, 1, 16'h9999, 0, 0, N / DPC);
        run_op(16'h0100, 16'h0001, 0, 1, 0);
        run_op(16'h0001, 16'h0002, 1, 1, 0);
`endif

        for (int k = 0; k < 200; k++) begin
            x = enc(longint'($urandom_range(0, int'(P - 1))));
            y = enc(longint'($urandom_range(0, int'(P - 1))));
            if ($urandom_range(0, 7) == 0) begin
                x[4*$urandom_range(0, N - 1) +: 4] = 4'($urandom_range(10, 15));
            end
            if ($urandom_range(0, 7) == 0) begin
                y[4*$urandom_range(0, N - 1) +: 4] = 4'($urandom_range(10, 15));
            end
            s = 1'b0;
`ifdef BCD_SUB_EN
            s = 1'($urandom);
`endif
            run_op(x, y, 1'($urandom), s, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
